// File: rtl/sync_fifo_flex.sv
// Single-clock valid/ready FIFO for any DEPTH >= 2, with occupancy, almost-full/empty,
// overflow, synchronous flush and an optional registered output stage.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2,
  parameter int OUT_REG    = 0,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [CW-1:0]         count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop, rd_adv, not_full;
  logic [DATA_WIDTH-1:0] rd_data;

  // Pointers wrap explicitly at DEPTH-1, so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign not_full       = (count_q < CW'(DEPTH));
  assign rd_data        = mem_q[rd_ptr_q];
  assign push           = s_valid_i & s_ready_o;
  assign pop            = m_valid_o & m_ready_i;
  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= CW'(AFULL_THR));
  assign almost_empty_o = (count_q <= CW'(AEMPTY_THR));
  assign overflow_o     = overflow_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_adv) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d    = count_q + CW'(push) - CW'(pop);
      overflow_d = s_valid_i & ~s_ready_o;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_data_i;
  end

  if (OUT_REG == 0) begin : g_fall_through
    assign rd_adv    = pop;
    assign m_valid_o = (count_q != '0);
    assign m_data_o  = m_valid_o ? rd_data : '0;
    // A write is still accepted when full if the head leaves in the same cycle.
    assign s_ready_o = not_full | m_ready_i;
  end else begin : g_out_reg
    logic                  oreg_vld_q, oreg_vld_d;
    logic [DATA_WIDTH-1:0] oreg_dat_q, oreg_dat_d;
    logic                  stor_nonempty;

    // count_q includes the output register, so storage holds count_q minus its valid bit.
    assign stor_nonempty = ((count_q - CW'(oreg_vld_q)) != '0);
    assign rd_adv        = (pop | ~oreg_vld_q) & stor_nonempty;
    assign m_valid_o     = oreg_vld_q;
    assign m_data_o      = oreg_vld_q ? oreg_dat_q : '0;
    assign s_ready_o     = not_full;

    always_comb begin
      oreg_vld_d = oreg_vld_q;
      oreg_dat_d = oreg_dat_q;
      if (flush_i) begin
        oreg_vld_d = 1'b0;
      end else if (rd_adv) begin
        oreg_vld_d = 1'b1;
        oreg_dat_d = rd_data;
      end else if (pop) begin
        oreg_vld_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        oreg_vld_q <= 1'b0;
        oreg_dat_q <= '0;
      end else begin
        oreg_vld_q <= oreg_vld_d;
        oreg_dat_q <= oreg_dat_d;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Randomised scoreboard bench for sync_fifo_flex: three configurations share one stimulus
// stream and are each compared every cycle against a queue-based reference model.
module tb_sync_fifo_flex;

  localparam int N = 3;
  // Per-instance configuration: depth, almost-full, almost-empty, output register.
  localparam int DEP [N]  = '{5, 5, 16};
  localparam int AFT [N]  = '{3, 3, 14};
  localparam int AET [N]  = '{1, 2, 2};
  localparam int OREG [N] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       m_ready = 1'b0;

  logic [N-1:0] mv, sr, af, ae, ov;
  logic [7:0]   md [N];
  logic [2:0]   cnt0, cnt1;
  logic [4:0]   cnt2;
  logic [4:0]   cnt [N];

  int tests = 0;
  int failed = 0;

  logic [7:0] mq [N][$];
  logic       pres [N];
  logic       ovf_exp [N];

  always #5 clk = ~clk;

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .AFULL_THR(3), .AEMPTY_THR(1), .OUT_REG(0)) u0 (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .s_valid_i(s_valid), .s_data_i(s_data),
    .s_ready_o(sr[0]), .m_valid_o(mv[0]), .m_data_o(md[0]), .m_ready_i(m_ready),
    .count_o(cnt0), .almost_full_o(af[0]), .almost_empty_o(ae[0]), .overflow_o(ov[0]));

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .AFULL_THR(3), .AEMPTY_THR(2), .OUT_REG(1)) u1 (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .s_valid_i(s_valid), .s_data_i(s_data),
    .s_ready_o(sr[1]), .m_valid_o(mv[1]), .m_data_o(md[1]), .m_ready_i(m_ready),
    .count_o(cnt1), .almost_full_o(af[1]), .almost_empty_o(ae[1]), .overflow_o(ov[1]));

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THR(14), .AEMPTY_THR(2), .OUT_REG(0)) u2 (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .s_valid_i(s_valid), .s_data_i(s_data),
    .s_ready_o(sr[2]), .m_valid_o(mv[2]), .m_data_o(md[2]), .m_ready_i(m_ready),
    .count_o(cnt2), .almost_full_o(af[2]), .almost_empty_o(ae[2]), .overflow_o(ov[2]));

  assign cnt[0] = {2'b00, cnt0};
  assign cnt[1] = {2'b00, cnt1};
  assign cnt[2] = cnt2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s u%0d count", tag, i), 32'(cnt[i]), 0);
      check($sformatf("%s u%0d m_valid", tag, i), 32'(mv[i]), 0);
      check($sformatf("%s u%0d m_data", tag, i), 32'(md[i]), 0);
      check($sformatf("%s u%0d s_ready", tag, i), 32'(sr[i]), 1);
      check($sformatf("%s u%0d almost_empty", tag, i), 32'(ae[i]), 1);
      check($sformatf("%s u%0d almost_full", tag, i), 32'(af[i]), 0);
      check($sformatf("%s u%0d overflow", tag, i), 32'(ov[i]), 0);
    end
  endtask

  // Monitor: outputs are checked mid-cycle, then the model advances by the edge to come
  // using the inputs that edge will see.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rstn) begin
        mq[i].delete();
        pres[i] = 1'b0;
        ovf_exp[i] = 1'b0;
      end else begin
        int n;
        logic exp_v, rdy, p_pop, p_push, newp;
        n = mq[i].size();
        exp_v = (OREG[i] != 0) ? pres[i] : (n != 0);
        rdy = (n < DEP[i]) || ((OREG[i] == 0) && m_ready);
        check($sformatf("u%0d m_valid", i), 32'(mv[i]), 32'(exp_v));
        if (mv[i]) begin
          if (n == 0) check($sformatf("u%0d valid_while_empty", i), 32'(mv[i]), 0);
          else        check($sformatf("u%0d m_data", i), 32'(md[i]), 32'(mq[i][0]));
        end else begin
          check($sformatf("u%0d m_data_idle", i), 32'(md[i]), 0);
        end
        check($sformatf("u%0d count", i), 32'(cnt[i]), n);
        check($sformatf("u%0d almost_full", i), 32'(af[i]), 32'(n >= AFT[i]));
        check($sformatf("u%0d almost_empty", i), 32'(ae[i]), 32'(n <= AET[i]));
        check($sformatf("u%0d s_ready", i), 32'(sr[i]), 32'(rdy));
        check($sformatf("u%0d overflow", i), 32'(ov[i]), 32'(ovf_exp[i]));
        if (flush) begin
          mq[i].delete();
          pres[i] = 1'b0;
          ovf_exp[i] = 1'b0;
        end else begin
          p_pop  = exp_v & m_ready;
          p_push = s_valid & rdy;
          newp   = pres[i];
          if (OREG[i] != 0) begin
            // Head enters the output register once it was already stored before this edge.
            if ((p_pop || !pres[i]) && (n - int'(pres[i])) > 0) newp = 1'b1;
            else if (p_pop) newp = 1'b0;
          end
          ovf_exp[i] = s_valid & ~rdy;
          if (p_pop) void'(mq[i].pop_front());
          if (p_push) mq[i].push_back(s_data);
          pres[i] = newp;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    flush   = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check_reset_vals("reset");
    @(posedge clk);
    #1 rstn = 1'b1;

    // Fill to full, one rejected write, then drain in order.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h15, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Full-rate streaming across several pointer wraps.
    for (int i = 0; i < 12; i++) drive(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Full plus simultaneous pop.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h45, 1'b1, 1'b0);
    drive(1'b1, 8'h46, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Latency and stall: head must hold while the consumer is stalled.
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    drive(1'b1, 8'hBB, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 50,
            $urandom_range(0, 59) == 0);

    // Flush with data present, concurrent write is dropped.
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Refill to three and reset asynchronously between edges.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1 check_reset_vals("async_reset");
    @(posedge clk);
    #1 rstn = 1'b1;

    // Post-reset traffic to show the FIFO resumes cleanly.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO with valid/ready on both ports. It holds exactly DEPTH entries for any DEPTH ≥ 2, not only powers of two. It reports occupancy and almost-full/almost-empty flags, supports synchronous flush, and offers an optional registered output stage for timing closure. It sits between pipeline stages in the arithmetic/memory datapath wherever elastic buffering with backpressure is needed.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width in bits (≥1)
- DEPTH, 16, number of storage entries (≥2, any integer)
- AFULL_THR, DEPTH-2, almost_full_o asserts when count ≥ AFULL_THR (1..DEPTH)
- AEMPTY_THR, 2, almost_empty_o asserts when count ≤ AEMPTY_THR (0..DEPTH-1)
- OUT_REG, 0, 0 = fall-through read from storage; 1 = registered output stage
- CW (local), log2ceil(DEPTH+1), count width; AW (local), log2ceil(DEPTH), pointer width

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous clear of all contents
- s_valid_i  in  1  write request
- s_data_i  in  DATA_WIDTH  write data
- s_ready_o  out  1  FIFO can accept a write this cycle
- m_valid_o  out  1  m_data_o holds a valid entry
- m_data_o  out  DATA_WIDTH  head-of-queue data
- m_ready_i  in  1  consumer accepts head this cycle
- count_o  out  CW  entries held, including the output register when OUT_REG=1
- almost_full_o  out  1  count_o ≥ AFULL_THR
- almost_empty_o  out  1  count_o ≤ AEMPTY_THR
- overflow_o  out  1  registered one-cycle pulse: s_valid_i high while s_ready_o low

## Operation
- push = s_valid_i & s_ready_o; pop = m_valid_o & m_ready_i. Both take effect at the same rising edge.
- Write pointer and read pointer run 0..DEPTH-1. Each wraps from DEPTH-1 to 0, with no power-of-two assumption.
- Full and empty are derived from the count register, not from pointer equality, so all DEPTH entries are usable.
- count_next = count + push − pop. It never exceeds DEPTH and never goes below 0.
- Storage array is not reset. m_data_o is forced to 0 whenever m_valid_o = 0.
- OUT_REG=0:
  - m_valid_o = (count ≠ 0); m_data_o = mem[rd_ptr].
  - s_ready_o = (count < DEPTH) | m_ready_i, so a write is accepted when full if a pop occurs in the same cycle.
- OUT_REG=1:
  - A single output register holds the head entry.
  - The register refills from storage on pop, or whenever it is empty and storage is non-empty.
  - s_ready_o = (count < DEPTH), with no same-cycle bypass.
- flush_i has priority over push and pop. At the next edge, pointers, count, output register valid bit and overflow_o all clear. Data presented that cycle is dropped.
- overflow_o is informational only. The rejected write is discarded and state is unchanged.

## Timing
- Reset (rstn_i low, asynchronous) drives:
  - m_valid_o=0, m_data_o=0, count_o=0, almost_full_o=0 (AFULL_THR ≥ 1), almost_empty_o=1, overflow_o=0
  - s_ready_o=1 (combinational from count=0)
- A reset asserted mid-operation discards all contents immediately. The flags reflect empty in the same cycle.
- OUT_REG=0: a push at edge N gives m_valid_o=1 and the data on m_data_o after edge N. Latency is 1 cycle.
- OUT_REG=1: a push at edge N into an empty FIFO moves to the output register at edge N+1, giving m_valid_o=1 after N+1. Latency is 2 cycles.
- count_o, almost_full_o and almost_empty_o are updated at the edge of the push/pop; the flags are combinational from the count register.
- Simultaneous push and pop with count ≠ 0: count is unchanged and both pointers advance.
- OUT_REG=0, push and pop while empty: the push is accepted and the pop does not occur, since m_valid_o is 0.
- Handshake: the consumer may assert m_ready_i at any time. The FIFO holds m_data_o stable while m_valid_o=1 and m_ready_i=0.

## Test plan
- Reset and flags, DEPTH=16, OUT_REG=0: release reset -> count_o=0, s_ready_o=1, m_valid_o=0, m_data_o=0, almost_empty_o=1.
- Fill and drain, DEPTH=5 (non-power-of-two): push 0x10..0x14 -> count_o=5, s_ready_o=0, almost_full_o=1 at count 3. A sixth s_valid_i gives overflow_o=1 for one cycle. Pop all -> 0x10..0x14 in order, count_o=0.
- Wrap-around: DEPTH=5, 12 push/pop cycles interleaved at full rate -> data order preserved across 2+ pointer wraps; count_o steady at 1.
- Full plus simultaneous pop, OUT_REG=0: at count=DEPTH, s_valid_i=1 and m_ready_i=1 -> write accepted, count_o stays DEPTH, head advances.
- OUT_REG=1 latency and stall: push 0xAA into empty -> m_valid_o high 2 edges later. Hold m_ready_i=0 for 4 cycles -> m_data_o=0xAA stable. Release -> next entry on the following cycle.
- Flush and async reset mid-stream: with count=7, assert flush_i together with s_valid_i -> next cycle count_o=0, m_valid_o=0, write dropped. Refill to 3, pulse rstn_i low between edges -> outputs return to reset values immediately.
